// File: rtl/seg7_scan_display_ctrl_pkg.sv
// seg7_pkg: shared state enum, segment codes and helpers for the scanned 7-segment display path
package seg7_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_CODE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
  };
  // ceil(w*log10(2)+1) using a fixed-point log10(2)
  function automatic int bcd_digits(int w);
    return w * 30103 / 100000 + 2;
  endfunction
  localparam int BCD_DIGITS_DEF = bcd_digits(11);
  function automatic logic [6:0] seg_encode(logic [3:0] n, logic blank, logic dash);
    return dash ? SEG_DASH : blank ? SEG_BLANK : SEG_CODE[n];
  endfunction
endpackage

// File: rtl/seg7_scan_display_ctrl_bin2bcd_iter.sv
// bin2bcd_iter: iterative double-dabble converter, one bit per cycle
module bin2bcd_iter
  import seg7_pkg::*;
#(
  parameter int W  = 11,
  parameter int ND = BCD_DIGITS_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [W-1:0]    din,
  input  logic            load,
  output logic            busy,
  output logic            done,
  output logic [4*ND-1:0] bcd
);
  localparam int CW = $clog2(W + 1);
  state_t state, state_n;
  logic [W-1:0] bin;
  logic [CW-1:0] cnt;
  logic [4*ND-1:0] adj;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = (state == IDLE) ? (load ? SHIFT : IDLE) :
              (state == SHIFT) ? (cnt == CW'(W - 1) ? LATCH : SHIFT) : IDLE;
    adj = bcd;
    for (int i = 0; i < ND; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
    end else if (state == IDLE && load) begin
      bin <= din;
      bcd <= '0;
      cnt <= '0;
    end else if (state == SHIFT) begin
      {bcd, bin} <= {adj, bin} << 1;
      cnt <= cnt + 1'b1;
    end
  assign busy = state != IDLE;
  assign done = state == LATCH;
endmodule

// File: rtl/seg7_scan_display_ctrl.sv
// seg7_scan_display_ctrl: measurement select, BCD conversion and multiplexed 7-segment scan
module seg7_scan_display_ctrl
  import seg7_pkg::*;
#(
  parameter int DATA_W   = 11,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DP_POS   = 0,
  parameter int SEG_AL   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] dato_a,
  input  logic [DATA_W-1:0] dato_b,
  input  logic              modo,
  input  logic              load,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] an
);
  localparam int ND = bcd_digits(DATA_W);
  localparam int XW = 4 * (ND > DIGITS ? ND : DIGITS);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic AL = SEG_AL != 0;
  logic [4*ND-1:0] bcd;
  logic [XW-1:0] bcd_x;
  logic [4*DIGITS-1:0] disp, disp_n;
  logic valid, valid_n, ovf_n, blank_n, dp_n;
  logic [SW-1:0] cnt;
  logic [IW-1:0] idx, idx_n;
  logic [6:0] seg_n;
  logic [DIGITS-1:0] an_n;
  bin2bcd_iter #(.W(DATA_W), .ND(ND)) u_conv (
    .clk(clk),
    .reset(reset),
    .din(modo ? dato_b : dato_a),
    .load(load),
    .busy(busy),
    .done(done),
    .bcd(bcd)
  );
  assign bcd_x   = XW'(bcd);
  assign disp_n  = done ? bcd_x[4*DIGITS-1:0] : disp;
  assign ovf_n   = done ? |(bcd_x >> (4 * DIGITS)) : overflow;
  assign valid_n = valid | done;
  assign idx_n   = (cnt == SW'(SCAN_DIV - 1)) ? (idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1) : idx;
  // Outputs are registered from next-state values so they track the display register without lag
  assign blank_n = idx_n != '0 && (disp_n >> (4 * idx_n)) == '0;
  assign seg_n   = seg_encode(disp_n[4*idx_n +: 4], blank_n, ovf_n);
  assign an_n    = DIGITS'(1) << idx_n;
  assign dp_n    = DP_POS < DIGITS && int'(idx_n) == DP_POS;
  // Display stays dark until the first conversion lands, and again after any reset
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt      <= '0;
      idx      <= '0;
      disp     <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
      seg      <= {7{AL}};
      an       <= {DIGITS{AL}};
      dp       <= AL;
    end else begin
      cnt      <= cnt == SW'(SCAN_DIV - 1) ? '0 : cnt + 1'b1;
      idx      <= idx_n;
      disp     <= disp_n;
      overflow <= ovf_n;
      valid    <= valid_n;
      seg      <= valid_n ? seg_n ^ {7{AL}} : {7{AL}};
      an       <= valid_n ? an_n ^ {DIGITS{AL}} : {DIGITS{AL}};
      dp       <= (valid_n & dp_n) ^ AL;
    end
endmodule

// File: tb/tb_seg7_scan_display_ctrl.sv
// tb_seg7_scan_display_ctrl: directed checks of conversion, scan, blanking, overflow and reset abort
module tb_seg7_scan_display_ctrl;
  logic clk = 1'b0, reset;
  logic [10:0] da, db;
  logic modo, load, busy, done, overflow, dp;
  logic [6:0] seg;
  logic [3:0] an;
  logic [13:0] da2, db2;
  logic modo2, load2, busy2, done2, overflow2, dp2;
  logic [6:0] seg2;
  logic [3:0] an2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  seg7_scan_display_ctrl #(.DATA_W(11), .DIGITS(4), .SCAN_DIV(4), .DP_POS(0), .SEG_AL(1)) u_a (
    .clk(clk), .reset(reset), .dato_a(da), .dato_b(db), .modo(modo), .load(load),
    .busy(busy), .done(done), .overflow(overflow), .seg(seg), .dp(dp), .an(an)
  );
  seg7_scan_display_ctrl #(.DATA_W(14), .DIGITS(4), .SCAN_DIV(4), .DP_POS(0), .SEG_AL(1)) u_b (
    .clk(clk), .reset(reset), .dato_a(da2), .dato_b(db2), .modo(modo2), .load(load2),
    .busy(busy2), .done(done2), .overflow(overflow2), .seg(seg2), .dp(dp2), .an(an2)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic load_a(logic m, logic [10:0] a, logic [10:0] b);
    modo = m;
    da = a;
    db = b;
    load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask
  task automatic wait_done(logic sel, string tag);
    for (int i = 0; i < 30 && !(sel ? done2 : done); i++) tick(1);
    check(tag, sel ? done2 : done, 1);
    tick(1);
  endtask
  task automatic show(logic sel, string tag, logic [3:0] an_e, logic [6:0] seg_e, logic dp_e);
    for (int i = 0; i < 40 && (sel ? an2 : an) != an_e; i++) tick(1);
    check({tag, "_an"}, sel ? an2 : an, an_e);
    check({tag, "_seg"}, sel ? seg2 : seg, seg_e);
    check({tag, "_dp"}, sel ? dp2 : dp, dp_e);
  endtask
  initial begin
    int n;
    reset = 1'b0;
    {da, db, modo, load} = '0;
    {da2, db2, modo2, load2} = '0;
    #2 reset = 1'b1;
    tick(3);
    check("t1_seg_rst", seg, 7'h7F);
    check("t1_an_rst", an, 4'hF);
    check("t1_dp_rst", dp, 1);
    check("t1_busy_rst", busy, 0);
    check("t1_ovf_rst", overflow, 0);
    reset = 1'b0;
    tick(5);
    check("t1_seg_idle", seg, 7'h7F);
    check("t1_an_idle", an, 4'hF);
    check("t1_busy_idle", busy, 0);
    // T2: 1234 from source A
    load_a(1'b0, 11'd1234, 11'd55);
    check("t2_busy_c1", busy, 1);
    check("t2_done_c1", done, 0);
    da = 11'd9;
    tick(10);
    check("t2_busy_c11", busy, 1);
    check("t2_done_c11", done, 0);
    tick(1);
    check("t2_done_c12", done, 1);
    tick(1);
    check("t2_done_c13", done, 0);
    check("t2_busy_c13", busy, 0);
    check("t2_ovf", overflow, 0);
    check("t2_an_live", an == 4'hF, 0);
    show(1'b0, "t2_d0", 4'b1110, 7'h19, 1'b0);
    show(1'b0, "t2_d1", 4'b1101, 7'h30, 1'b1);
    show(1'b0, "t2_d2", 4'b1011, 7'h24, 1'b1);
    show(1'b0, "t2_d3", 4'b0111, 7'h79, 1'b1);
    // T3: 7 from source B, upper digits blanked
    load_a(1'b1, 11'd1234, 11'd7);
    wait_done(1'b0, "t3_done");
    show(1'b0, "t3_d0", 4'b1110, 7'h78, 1'b0);
    show(1'b0, "t3_d1", 4'b1101, 7'h7F, 1'b1);
    show(1'b0, "t3_d2", 4'b1011, 7'h7F, 1'b1);
    show(1'b0, "t3_d3", 4'b0111, 7'h7F, 1'b1);
    // T4: 14-bit instance, 12000 overflows four digits
    da2 = 14'd12000;
    load2 = 1'b1;
    tick(1);
    load2 = 1'b0;
    wait_done(1'b1, "t4_done");
    check("t4_ovf", overflow2, 1);
    show(1'b1, "t4_d0", 4'b1110, 7'h3F, 1'b0);
    show(1'b1, "t4_d2", 4'b1011, 7'h3F, 1'b1);
    show(1'b1, "t4_d3", 4'b0111, 7'h3F, 1'b1);
    // T5: second load while busy is dropped
    load_a(1'b0, 11'd42, 11'd0);
    tick(2);
    load_a(1'b0, 11'd999, 11'd0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) n++;
      tick(1);
    end
    check("t5_done_count", n, 1);
    show(1'b0, "t5_d0", 4'b1110, 7'h24, 1'b0);
    show(1'b0, "t5_d1", 4'b1101, 7'h19, 1'b1);
    show(1'b0, "t5_d2", 4'b1011, 7'h7F, 1'b1);
    // T6: reset during SHIFT aborts
    load_a(1'b0, 11'd500, 11'd0);
    tick(4);
    reset = 1'b1;
    #1;
    check("t6_seg_rst", seg, 7'h7F);
    check("t6_an_rst", an, 4'hF);
    check("t6_dp_rst", dp, 1);
    check("t6_busy_rst", busy, 0);
    tick(2);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) n++;
      tick(1);
    end
    check("t6_no_done", n, 0);
    check("t6_an_dark", an, 4'hF);
    load_a(1'b0, 11'd0, 11'd0);
    wait_done(1'b0, "t6_done");
    show(1'b0, "t6_d0", 4'b1110, 7'h40, 1'b0);
    show(1'b0, "t6_d1", 4'b1101, 7'h7F, 1'b1);
    show(1'b0, "t6_d3", 4'b0111, 7'h7F, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
